// File: rtl/shared_divider.sv
// Iterative unsigned restoring divider shared by the bike-computer measurement blocks.
// Define DIV_REMAINDER_EN to add the remainder output port and its register.
module shared_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             busy,
  output logic             ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, q, dvsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc_shift;
  logic [WIDTH-1:0] acc_next, q_next;
  logic             fits, accept, last;

  // start is honoured in IDLE and in DONE (back-to-back); never while running
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    ready = (state == DONE);
  end

  // The shifted partial remainder needs one extra bit before the compare.
  always_comb begin
    acc_shift = {acc, q[WIDTH-1]};
    fits      = (acc_shift >= {1'b0, dvsr});
    acc_next  = fits ? WIDTH'(acc_shift - {1'b0, dvsr}) : acc_shift[WIDTH-1:0];
    q_next    = {q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      q      <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      result <= '0;
`ifdef DIV_REMAINDER_EN
      remainder <= '0;
`endif
    end else if (accept) begin
      acc  <= '0;
      q    <= dividend;
      dvsr <= divisor;
      cnt  <= CNT_W'(WIDTH);
    end else if (state == RUN) begin
      acc <= acc_next;
      q   <= q_next;
      cnt <= cnt - CNT_W'(1);
      // Outputs only move on the final iteration, i.e. on entry to DONE
      if (last) begin
        result <= q_next;
`ifdef DIV_REMAINDER_EN
        remainder <= acc_next;
`endif
      end
    end
  end

endmodule
